vram_arbiter: RTL

//  Shares the single 2K x 8 synchronous text VRAM between the video character

---
 rtl/vram_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
//
// Shares the single-port 2K x 8 synchronous text VRAM between the video
// character fetcher and a host/CPU port. Video reads always take the VRAM in
// the cycle they are requested. A CPU access is granted only in a cycle with
// no video request, and completes with a one-cycle cpu_ack two cycles after
// the grant.
//
// Ports
//   clk, reset_n          system clock (rising edge), async active-low reset
//   vid_req/vid_addr      video read request and address (never stalled)
//   vid_data/vid_valid    video read data (straight from VRAM) / request
//                         delayed by one cycle
//   cpu_req/cpu_we        CPU request (held until ack) and write select
//   cpu_addr/cpu_wdata    CPU address and write data, stable while requesting
//   cpu_rdata/cpu_ack     registered read data and one-cycle completion pulse
//   cpu_starve            current CPU request has waited >= MAX_WAIT cycles
//   sram_addr/sram_we     VRAM address mux and write enable (combinational)
//   sram_wdata/sram_rdata VRAM write data and read data (one-cycle latency)
//
// Optional build macro
//   VRAM_ARB_STATS_EN     adds stats_clr (in) and stats_wait (out, CNT_W bits):
//                         saturating count of cycles the CPU was held off by
//                         video, synchronously cleared by stats_clr.
//
// Parameters: AW, DW, MAX_WAIT, CNT_W (CNT_W at most 32).
// -----------------------------------------------------------------------------
// state | meaning
// IDLE  | no CPU access in flight; grant when CPU requests and video is idle
// DATA  | granted access is at the VRAM; read data arrives this cycle
// ACK   | cpu_ack high for this one cycle; requester drops cpu_req
// -----------------------------------------------------------------------------
module vram_arbiter #(
  parameter int AW       = 11,
  parameter int DW       = 8,
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic [DW-1:0] vid_data,
  output logic          vid_valid,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_starve,
`ifdef VRAM_ARB_STATS_EN
  input  logic             stats_clr,
  output logic [CNT_W-1:0] stats_wait,
`endif
  output logic [AW-1:0] sram_addr,
  output logic          sram_we,
  output logic [DW-1:0] sram_wdata,
  input  logic [DW-1:0] sram_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_next;
  logic [CNT_W-1:0] wait_inc;
  logic [31:0]      wait_inc_w;
  logic             starve_next;
  logic             ack_next;
  logic [DW-1:0]    rdata_next;
  logic             wr_q;
  logic             wr_next;
  logic             grant;
  logic             contend;

  // cpu_ack can only be high in ACK, so the ack term is belt-and-braces
  // protection against re-granting a request the host has not yet dropped.
  assign grant   = (state == IDLE) & cpu_req & ~vid_req & ~cpu_ack;
  assign contend = (state == IDLE) & cpu_req & vid_req;

  assign sram_addr  = vid_req ? vid_addr : cpu_addr;
  // Gate with reset so a held write request cannot corrupt VRAM while the
  // FSM sits in reset (which forces IDLE and would otherwise look like a grant).
  assign sram_we    = reset_n & grant & cpu_we;
  assign sram_wdata = cpu_wdata;
  assign vid_data   = sram_rdata;

  assign wait_inc   = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + CNT_W'(1);
  assign wait_inc_w = 32'(wait_inc);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      cpu_starve <= 1'b0;
      cpu_ack    <= 1'b0;
      cpu_rdata  <= '0;
      wr_q       <= 1'b0;
      vid_valid  <= 1'b0;
    end else begin
      state      <= state_next;
      wait_cnt   <= wait_next;
      cpu_starve <= starve_next;
      cpu_ack    <= ack_next;
      cpu_rdata  <= rdata_next;
      wr_q       <= wr_next;
      vid_valid  <= vid_req;
    end
  end

  always_comb begin
    state_next  = state;
    wait_next   = wait_cnt;
    starve_next = cpu_starve;
    ack_next    = 1'b0;
    rdata_next  = cpu_rdata;
    wr_next     = wr_q;
    case (state)
      IDLE: begin
        if (grant) begin
          // Starve flag deliberately survives the grant; it clears in ACK.
          state_next = DATA;
          wait_next  = '0;
          wr_next    = cpu_we;
        end else if (contend) begin
          wait_next   = wait_inc;
          starve_next = (wait_inc_w >= 32'(MAX_WAIT));
        end else if (!cpu_req) begin
          // Request abandoned (or none): nothing is waiting any more.
          wait_next   = '0;
          starve_next = 1'b0;
        end
      end
      DATA: begin
        // Write direction captured at grant so the host may change cpu_we
        // once the access is under way without corrupting cpu_rdata.
        if (!wr_q) begin
          rdata_next = sram_rdata;
        end
        ack_next   = 1'b1;
        state_next = ACK;
      end
      ACK: begin
        ack_next    = 1'b0;
        starve_next = 1'b0;
        state_next  = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

`ifdef VRAM_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stats_wait <= '0;
    end else if (stats_clr) begin
      stats_wait <= '0;
    end else if (contend && (stats_wait != CNT_MAX)) begin
      stats_wait <= stats_wait + CNT_W'(1);
    end
  end
`endif

endmodule
